// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives comparator B with a probe
// value and narrows [lo, hi] from the equal/less/great flags until it converges.
module sar_search_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             cmp_equal,
    input  logic             cmp_less,
    input  logic             cmp_great,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             error
);

    localparam int unsigned BW = WIDTH + 1;
    localparam int unsigned SW = WIDTH + 2;

    typedef enum logic {
        IDLE,
        PROBE
    } state_e;

    state_e           state_q, state_d;
    logic [BW-1:0]    lo_q, lo_d, hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             error_q, error_d;

    logic [BW-1:0]    guess_ext_c;
    logic [BW-1:0]    lo_nx_c, hi_nx_c;
    logic             narrow_c;
    logic             empty_c;

    // Next-state and bound-narrowing logic
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        guess_d     = guess_q;
        result_d    = result_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        found_d     = found_q;
        error_d     = error_q;
        guess_ext_c = BW'(guess_q);
        lo_nx_c     = lo_q;
        hi_nx_c     = hi_q;
        narrow_c    = 1'b0;
        empty_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = {1'b0, {WIDTH{1'b1}}};
                    guess_d  = {1'b0, {(WIDTH-1){1'b1}}};
                    result_d = '0;
                    found_d  = 1'b0;
                    error_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = PROBE;
                end
            end
            PROBE: begin
                case ({cmp_equal, cmp_less, cmp_great})
                    3'b100: begin
                        result_d = guess_q;
                        found_d  = 1'b1;
                        error_d  = 1'b0;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end
                    3'b010: begin
                        narrow_c = 1'b1;
                        // guess == lo means hi would drop below lo (and below zero)
                        empty_c  = (guess_ext_c == lo_q);
                        hi_nx_c  = guess_ext_c - BW'(1);
                    end
                    3'b001: begin
                        narrow_c = 1'b1;
                        lo_nx_c  = guess_ext_c + BW'(1);
                        empty_c  = (lo_nx_c > hi_q);
                    end
                    default: begin
                        found_d = 1'b0;
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                endcase

                if (narrow_c) begin
                    if (empty_c) begin
                        result_d = '0;
                        found_d  = 1'b0;
                        error_d  = 1'b1;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        lo_d    = lo_nx_c;
                        hi_d    = hi_nx_c;
                        guess_d = WIDTH'((SW'(lo_nx_c) + SW'(hi_nx_c)) >> 1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            error_q  <= error_d;
        end
    end

    assign guess  = guess_q;
    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign error  = error_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl: ideal or faulty comparator model around the
// DUT, expected guess sequences and results computed by hand.
module tb_sar_search_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] guess;
    logic       cmp_equal, cmp_less, cmp_great;
    logic       busy, done, found, error;
    logic [3:0] result;

    logic [3:0] target;
    int         mode;
    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_seq [6];

    sar_search_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .guess    (guess),
        .cmp_equal(cmp_equal),
        .cmp_less (cmp_less),
        .cmp_great(cmp_great),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .found    (found),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Comparator model: 0 ideal, 1 stuck great, otherwise all flags low
    always_comb begin
        case (mode)
            0:       {cmp_equal, cmp_less, cmp_great} = {target == guess, target < guess, target > guess};
            1:       {cmp_equal, cmp_less, cmp_great} = 3'b001;
            default: {cmp_equal, cmp_less, cmp_great} = 3'b000;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one search and follow it to its done pulse
    task automatic run(input int n, input logic [3:0] exp_res, input logic exp_found,
                       input logic exp_err);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("guess[%0d]", i), 8'(guess), 8'(exp_seq[i]));
            chk($sformatf("busy[%0d]", i), 8'(busy), 8'(1));
            chk($sformatf("nodone[%0d]", i), 8'(done), 8'(0));
            tick();
        end
        chk("done", 8'(done), 8'(1));
        chk("busy_end", 8'(busy), 8'(0));
        chk("result", 8'(result), 8'(exp_res));
        chk("found", 8'(found), 8'(exp_found));
        chk("error", 8'(error), 8'(exp_err));
        tick();
        chk("done_drop", 8'(done), 8'(0));
        chk("result_hold", 8'(result), 8'(exp_res));
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        target = 4'd0;
        mode   = 0;
        exp_seq = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        #12;
        chk("rst_guess", 8'(guess), 8'(0));
        chk("rst_busy", 8'(busy), 8'(0));
        chk("rst_done", 8'(done), 8'(0));
        chk("rst_result", 8'(result), 8'(0));
        chk("rst_found", 8'(found), 8'(0));
        chk("rst_error", 8'(error), 8'(0));
        rst_n = 1'b1;
        tick();

        // Target 7: hit on the first probe
        target = 4'd7;
        exp_seq = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        run(1, 4'd7, 1'b1, 1'b0);

        // Target 0: lower edge
        target = 4'd0;
        exp_seq = '{4'd7, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0};
        run(4, 4'd0, 1'b1, 1'b0);

        // Target 15: upper edge, lo must not wrap
        target = 4'd15;
        exp_seq = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15, 4'd0};
        run(5, 4'd15, 1'b1, 1'b0);

        // Target 12: mixed great/less path
        target = 4'd12;
        exp_seq = '{4'd7, 4'd11, 4'd13, 4'd12, 4'd0, 4'd0};
        run(4, 4'd12, 1'b1, 1'b0);

        // Comparator stuck at great: range empties after probing 15
        mode = 1;
        exp_seq = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15, 4'd0};
        run(5, 4'd0, 1'b0, 1'b1);

        // No flags at all on the first probe
        mode = 2;
        exp_seq = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        run(1, 4'd0, 1'b0, 1'b1);

        // Flags are ignored while idle
        tick();
        tick();
        chk("idle_done", 8'(done), 8'(0));
        chk("idle_error_hold", 8'(error), 8'(1));
        chk("idle_guess_hold", 8'(guess), 8'(7));
        mode = 0;

        // Target 5 with asynchronous reset after the second probe
        target = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r_guess0", 8'(guess), 8'(7));
        tick();
        chk("r_guess1", 8'(guess), 8'(3));
        tick();
        chk("r_guess2", 8'(guess), 8'(5));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 8'(busy), 8'(0));
        chk("ar_done", 8'(done), 8'(0));
        chk("ar_guess", 8'(guess), 8'(0));
        chk("ar_result", 8'(result), 8'(0));
        tick();
        chk("ar_nodone", 8'(done), 8'(0));
        rst_n = 1'b1;
        tick();
        exp_seq = '{4'd7, 4'd3, 4'd5, 4'd0, 4'd0, 4'd0};
        run(3, 4'd5, 1'b1, 1'b0);

        // start held high: ignored while busy, accepted in the done cycle
        target = 4'd3;
        start = 1'b1;
        tick();
        chk("b2b_g0", 8'(guess), 8'(7));
        tick();
        chk("b2b_g1", 8'(guess), 8'(3));
        chk("b2b_busy1", 8'(busy), 8'(1));
        tick();
        chk("b2b_done", 8'(done), 8'(1));
        chk("b2b_result", 8'(result), 8'(3));
        chk("b2b_found", 8'(found), 8'(1));
        tick();
        chk("b2b_restart_g", 8'(guess), 8'(7));
        chk("b2b_restart_busy", 8'(busy), 8'(1));
        chk("b2b_restart_done", 8'(done), 8'(0));
        chk("b2b_cleared_found", 8'(found), 8'(0));
        chk("b2b_cleared_result", 8'(result), 8'(0));
        start = 1'b0;
        tick();
        chk("b2b_g1b", 8'(guess), 8'(3));
        tick();
        chk("b2b_done2", 8'(done), 8'(1));
        chk("b2b_result2", 8'(result), 8'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
